alu_seq: RTL and testbench

- Parametrised, clocked successor to the 8-bit ripple ALU.
- Arithmetic, logic and variable-amount shift ops on WIDTH-bit operands.
- Input and output use valid/ready handshakes; results and flags are registered.
- Multi-cycle ops (shift, optional multiply) are sequenced by an FSM. The block sits between the register file and the writeback stage of the datapath.

---
 rtl/alu_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: add/sub/logic/variable shift on WIDTH-bit operands; ALU_SEQ_MUL_EN adds a shift-add multiply.
// Latency: 1 cycle for single-cycle ops, n+1 for a shift by n, WIDTH+1 for multiply.
// Backpressure: in_ready only in IDLE; the result and flags stay frozen in DONE until out_ready.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow,
   output logic             err,
   output logic             busy
);
   localparam int SW = $clog2(WIDTH);

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic             shl_q;
   logic [SW:0]      cnt;

   logic [WIDTH:0]   sum_add;
   logic [WIDTH:0]   sum_sub;
   logic [WIDTH-1:0] fin_res;
   logic             fin_c;
   logic             fin_v;
   logic             fin_err;
   logic             is_shift;
   logic [SW-1:0]    shamt;
   logic [WIDTH-1:0] sh_next;
   logic             sh_out;

   assign sum_add  = {1'b0, a} + {1'b0, b};
   assign sum_sub  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign is_shift = (op == 4'b0110) || (op == 4'b0111);
   assign shamt    = b[SW-1:0];

   // One shift step; the bit leaving the register becomes the carry
   assign sh_out  = shl_q ? acc[WIDTH-1] : acc[0];
   assign sh_next = shl_q ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};

   always_comb begin
      fin_res = '0;
      fin_c   = 1'b0;
      fin_v   = 1'b0;
      fin_err = 1'b0;
      case (op)
         4'b0000: begin
            {fin_c, fin_res} = sum_add;
            fin_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0001: begin
            {fin_c, fin_res} = sum_sub;
            fin_v = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0010: fin_res = a & b;
         4'b0011: fin_res = a | b;
         4'b0100: fin_res = a ^ b;
         4'b0101: fin_res = ~(a ^ b);
         4'b0110, 4'b0111: fin_res = a;
`ifdef ALU_SEQ_MUL_EN
         4'b1000: fin_res = '0;
`endif
         default: fin_err = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_next;

   // prod holds {partial sum, remaining multiplier bits}; one multiplier bit retires per cycle
   assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
   assign prod_next = {mul_sum, prod[WIDTH-1:1]};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         carry     <= 1'b0;
         negative  <= 1'b0;
         overflow  <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         acc       <= '0;
         shl_q     <= 1'b0;
         cnt       <= '0;
`ifdef ALU_SEQ_MUL_EN
         mcand     <= '0;
         prod      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (is_shift && (shamt != '0)) begin
                     state <= SHIFT;
                     acc   <= a;
                     shl_q <= (op == 4'b0110);
                     cnt   <= {1'b0, shamt};
                  end
`ifdef ALU_SEQ_MUL_EN
                  else if (op == 4'b1000) begin
                     state <= MUL;
                     mcand <= a;
                     prod  <= {{WIDTH{1'b0}}, b};
                     cnt   <= (SW+1)'(WIDTH);
                  end
`endif
                  else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     result    <= fin_res;
                     zero      <= (fin_res == '0);
                     negative  <= fin_res[WIDTH-1];
                     carry     <= fin_c;
                     overflow  <= fin_v;
                     err       <= fin_err;
                  end
               end
            end
            SHIFT: begin
               acc <= sh_next;
               cnt <= cnt - 1'b1;
               if (cnt == (SW+1)'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= sh_next;
                  zero      <= (sh_next == '0);
                  negative  <= sh_next[WIDTH-1];
                  carry     <= sh_out;
                  overflow  <= 1'b0;
                  err       <= 1'b0;
               end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
               prod <= prod_next;
               cnt  <= cnt - 1'b1;
               if (cnt == (SW+1)'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= prod_next[WIDTH-1:0];
                  zero      <= (prod_next[WIDTH-1:0] == '0);
                  negative  <= prod_next[WIDTH-1];
                  carry     <= (prod_next[2*WIDTH-1:WIDTH] != '0);
                  overflow  <= (prod_next[2*WIDTH-1:WIDTH] != '0);
                  err       <= 1'b0;
               end
            end
`endif
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8; multiply vectors follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       zero;
   logic       carry;
   logic       negative;
   logic       overflow;
   logic       err;
   logic       busy;

   int total = 0;
   int bad   = 0;

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .carry(carry), .negative(negative),
      .overflow(overflow), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // Present one op for a single cycle, then scramble the inputs to prove they were latched
   task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
   endtask

   // Count negedges after acceptance until out_valid, bounded
   task automatic wait_out(input string tag, input int exp_wait);
      int cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk(tag, cyc, exp_wait);
   endtask

   task automatic take(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk(tag, {out_valid, in_ready, busy}, 3'b010);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst_ctl", {in_ready, out_valid, busy}, 3'b100);
      chk("rst_res", result, 8'h00);
      chk("rst_flags", {zero, carry, negative, overflow, err}, 5'b00000);
      reset = 1'b0;

      // flags packed as {zero, carry, negative, overflow, err}
      issue(4'b0000, 8'hF0, 8'h20);
      wait_out("add_lat", 0);
      chk("add_res", result, 8'h10);
      chk("add_flags", {zero, carry, negative, overflow, err}, 5'b01000);
      take("add_take");

      issue(4'b0001, 8'h80, 8'h01);
      wait_out("sub1_lat", 0);
      chk("sub1_res", result, 8'h7F);
      chk("sub1_flags", {zero, carry, negative, overflow, err}, 5'b01010);
      take("sub1_take");

      issue(4'b0001, 8'h05, 8'h05);
      wait_out("sub2_lat", 0);
      chk("sub2_res", result, 8'h00);
      chk("sub2_flags", {zero, carry, negative, overflow, err}, 5'b11000);
      take("sub2_take");

      issue(4'b0001, 8'h03, 8'h05);
      wait_out("sub3_lat", 0);
      chk("sub3_res", result, 8'hFE);
      chk("sub3_flags", {zero, carry, negative, overflow, err}, 5'b00100);
      take("sub3_take");

      issue(4'b0110, 8'h81, 8'h03);
      chk("shl_busy", {busy, in_ready, out_valid}, 3'b100);
      wait_out("shl_lat", 3);
      chk("shl_res", result, 8'h08);
      chk("shl_flags", {zero, carry, negative, overflow, err}, 5'b00000);
      take("shl_take");

      issue(4'b0111, 8'h81, 8'h00);
      wait_out("shr0_lat", 0);
      chk("shr0_res", result, 8'h81);
      chk("shr0_flags", {zero, carry, negative, overflow, err}, 5'b00100);
      take("shr0_take");

      issue(4'b0111, 8'h81, 8'h01);
      wait_out("shr1_lat", 1);
      chk("shr1_res", result, 8'h40);
      chk("shr1_flags", {zero, carry, negative, overflow, err}, 5'b01000);
      take("shr1_take");

      issue(4'b0101, 8'h0F, 8'h3C);
      wait_out("xnor_lat", 0);
      chk("xnor_res", result, 8'hCC);
      take("xnor_take");

      // Result must hold under backpressure while a competing op is offered
      issue(4'b0100, 8'hAA, 8'hFF);
      wait_out("xor_lat", 0);
      op = 4'b0000; a = 8'h01; b = 8'h01; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("xor_hold", {result, out_valid, in_ready}, {8'h55, 1'b1, 1'b0});
      end
      in_valid = 1'b0;
      take("xor_take");
      chk("xor_after", result, 8'h55);

      issue(4'b1111, 8'h12, 8'h34);
      wait_out("ill_lat", 0);
      chk("ill_res", result, 8'h00);
      chk("ill_flags", {zero, carry, negative, overflow, err}, 5'b10001);
      take("ill_take");

      issue(4'b1000, 8'h10, 8'h11);
`ifdef ALU_SEQ_MUL_EN
      wait_out("mul_lat", 8);
      chk("mul_res", result, 8'h10);
      chk("mul_flags", {zero, carry, negative, overflow, err}, 5'b01010);
`else
      wait_out("mul_lat", 0);
      chk("mul_res", result, 8'h00);
      chk("mul_flags", {zero, carry, negative, overflow, err}, 5'b10001);
`endif
      take("mul_take");

      // Abandon a shift in its second cycle
      issue(4'b0110, 8'h01, 8'h05);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_ctl", {out_valid, in_ready, busy}, 3'b010);
      chk("mid_rst_res", result, 8'h00);
      reset = 1'b0;
      issue(4'b0000, 8'h01, 8'h01);
      wait_out("post_rst_lat", 0);
      chk("post_rst_res", result, 8'h02);
      take("post_rst_take");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
